down_cnt_8: RTL and testbench

DOWN_CNT_8 -- requirements
Module: down_cnt_8

---
 rtl/down_cnt_8_pkg.sv | 28 ++
 rtl/down_cnt_8_dec.sv | 36 +++
 rtl/down_cnt_8.sv | 77 +++++++
 tb/tb_down_cnt_8.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/down_cnt_8_pkg.sv
// Shared definitions for the 8-bit down counter.
// Holds the FSM encoding and datapath constants.
package down_cnt_8_pkg;

    localparam int unsigned W = 8;

    localparam logic [W-1:0] ZERO8 = 8'h00;
    localparam logic [W-1:0] ONES8 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } state_t;

    // Next-cycle register values produced by the control logic.
    typedef struct packed {
        state_t       state;
        logic [W-1:0] count;
        logic [W-1:0] reload;
        logic         done;
    } cnt_next_t;

    function automatic logic is_zero(input logic [W-1:0] v);
        return v == ZERO8;
    endfunction

endpackage

// File: rtl/down_cnt_8_dec.sv
// Decrement-by-one datapath for the down counter.
// dec_8 adds all-ones to the operand using the plain 8-bit adder.
import down_cnt_8_pkg::*;

module add8 (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

module dec_8 (
    output logic [W-1:0] out,
    output logic         bout,
    input  logic [W-1:0] a
);

    // a - 1 == a + 0xFF (mod 256); carry-out is high whenever a != 0.
    add8 u_add8 (
        .a    (a),
        .b    (ONES8),
        .cin  (1'b0),
        .sum  (out),
        .cout (bout)
    );

endmodule

// File: rtl/down_cnt_8.sv
// 8-bit loadable down counter with terminal-count pulse.
// Three-state FSM: IDLE, RUN, EXPIRED; optional auto-reload.
import down_cnt_8_pkg::*;

module down_cnt_8 (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic         auto_rl,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         zero,
    output logic         done
);

    state_t       state;
    logic [W-1:0] reload_reg;
    logic [W-1:0] dec_val;
    logic         dec_unused_bout;
    cnt_next_t    nxt;

    dec_8 u_dec (
        .out  (dec_val),
        .bout (dec_unused_bout),
        .a    (count)
    );

    // Next-state and next-datapath decode; priority clr > load > en.
    always_comb begin
        nxt.state  = state;
        nxt.count  = count;
        nxt.reload = reload_reg;
        nxt.done   = 1'b0;
        if (clr) begin
            nxt.state = IDLE;
            nxt.count = ZERO8;
        end else if (load) begin
            nxt.state  = RUN;
            nxt.count  = ld_val;
            nxt.reload = ld_val;
        end else if (state == RUN && en) begin
            if (!is_zero(count)) begin
                nxt.count = dec_val;
            end else begin
                nxt.done = 1'b1;
                if (auto_rl) begin
                    nxt.count = reload_reg;
                end else begin
                    nxt.state = EXPIRED;
                end
            end
        end
    end

    // State and output registers; reset discards any count in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= ZERO8;
            reload_reg <= ZERO8;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt.state;
            count      <= nxt.count;
            reload_reg <= nxt.reload;
            done       <= nxt.done;
            busy       <= (nxt.state == RUN);
        end
    end

    assign zero = is_zero(count);

endmodule

// File: tb/tb_down_cnt_8.sv
// Scoreboard bench for down_cnt_8 with directed vectors.
// Stimulus queues expected outputs; a monitor compares at negedge.
module tb_down_cnt_8;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [7:0] ld_val;
    logic       en;
    logic       auto_rl;
    logic [7:0] count;
    logic       busy;
    logic       zero;
    logic       done;

    typedef struct {
        string      name;
        logic [7:0] count;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   n_tests;
    int   n_fail;

    down_cnt_8 dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .load    (load),
        .ld_val  (ld_val),
        .en      (en),
        .auto_rl (auto_rl),
        .count   (count),
        .busy    (busy),
        .zero    (zero),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: registered outputs are stable at negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ez;
            e  = q.pop_front();
            ez = (e.count == 8'h00);
            n_tests++;
            if (count !== e.count || busy !== e.busy ||
                done !== e.done || zero !== ez) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d busy=%b zero=%b done=%b, want cnt=%0d busy=%b zero=%b done=%b",
                         e.name, count, busy, zero, done,
                         e.count, e.busy, ez, e.done);
            end
        end
    end

    task automatic cyc(input string nm, input logic c, input logic l,
                       input logic [7:0] v, input logic e, input logic a,
                       input logic [7:0] xc, input logic xb,
                       input logic xd);
        exp_t x;
        @(negedge clk);
        clr = c; load = l; ld_val = v; en = e; auto_rl = a;
        @(posedge clk);
        x.name = nm; x.count = xc; x.busy = xb; x.done = xd;
        q.push_back(x);
    endtask

    task automatic check_now(input string nm, input logic [7:0] xc,
                             input logic xb, input logic xd);
        n_tests++;
        if (count !== xc || busy !== xb || done !== xd ||
            zero !== (xc == 8'h00)) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d busy=%b zero=%b done=%b, want cnt=%0d busy=%b done=%b",
                     nm, count, busy, zero, done, xc, xb, xd);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; clr = 1'b0; load = 1'b0; ld_val = 8'h00;
        en = 1'b0; auto_rl = 1'b0;
        #1;
        check_now("reset_async", 8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // load 3, continuous enable, expire
        cyc("l3_load", 0, 1, 8'd3, 1, 0, 8'd3, 1, 0);
        cyc("l3_c2",   0, 0, 8'd0, 1, 0, 8'd2, 1, 0);
        cyc("l3_c1",   0, 0, 8'd0, 1, 0, 8'd1, 1, 0);
        cyc("l3_c0",   0, 0, 8'd0, 1, 0, 8'd0, 1, 0);
        cyc("l3_done", 0, 0, 8'd0, 1, 0, 8'd0, 0, 1);
        cyc("l3_exp1", 0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        cyc("l3_exp2", 0, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // load 5, enable toggling
        cyc("l5_load", 0, 1, 8'd5, 0, 0, 8'd5, 1, 0);
        cyc("l5_e1",   0, 0, 8'd0, 1, 0, 8'd4, 1, 0);
        cyc("l5_e0",   0, 0, 8'd0, 0, 0, 8'd4, 1, 0);
        cyc("l5_e2",   0, 0, 8'd0, 1, 0, 8'd3, 1, 0);
        cyc("l5_e0b",  0, 0, 8'd0, 0, 0, 8'd3, 1, 0);
        cyc("l5_e3",   0, 0, 8'd0, 1, 0, 8'd2, 1, 0);
        cyc("l5_e0c",  0, 0, 8'd0, 0, 0, 8'd2, 1, 0);
        cyc("l5_e4",   0, 0, 8'd0, 1, 0, 8'd1, 1, 0);
        cyc("l5_e0d",  0, 0, 8'd0, 0, 0, 8'd1, 1, 0);
        cyc("l5_e5",   0, 0, 8'd0, 1, 0, 8'd0, 1, 0);
        cyc("l5_e0e",  0, 0, 8'd0, 0, 0, 8'd0, 1, 0);
        cyc("l5_done", 0, 0, 8'd0, 1, 0, 8'd0, 0, 1);

        // load 2 with auto-reload
        cyc("ar_load", 0, 1, 8'd2, 1, 1, 8'd2, 1, 0);
        cyc("ar_1",    0, 0, 8'd0, 1, 1, 8'd1, 1, 0);
        cyc("ar_0",    0, 0, 8'd0, 1, 1, 8'd0, 1, 0);
        cyc("ar_rl1",  0, 0, 8'd0, 1, 1, 8'd2, 1, 1);
        cyc("ar_1b",   0, 0, 8'd0, 1, 1, 8'd1, 1, 0);
        cyc("ar_0b",   0, 0, 8'd0, 1, 1, 8'd0, 1, 0);
        cyc("ar_rl2",  0, 0, 8'd0, 1, 1, 8'd2, 1, 1);
        cyc("ar_clr",  1, 0, 8'd0, 1, 1, 8'd0, 0, 0);

        // reload over a running count, then clr beats load
        cyc("rl_load", 0, 1, 8'd6, 1, 0, 8'd6, 1, 0);
        cyc("rl_5",    0, 0, 8'd0, 1, 0, 8'd5, 1, 0);
        cyc("rl_4",    0, 0, 8'd0, 1, 0, 8'd4, 1, 0);
        cyc("rl_ld9",  0, 1, 8'd9, 1, 0, 8'd9, 1, 0);
        cyc("rl_8",    0, 0, 8'd0, 1, 0, 8'd8, 1, 0);
        cyc("rl_clr",  1, 1, 8'd33, 1, 0, 8'd0, 0, 0);
        cyc("idle_en", 0, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // load 0 expires on first enabled edge
        cyc("z_load",  0, 1, 8'd0, 0, 0, 8'd0, 1, 0);
        cyc("z_hold",  0, 0, 8'd0, 0, 0, 8'd0, 1, 0);
        cyc("z_done",  0, 0, 8'd0, 1, 0, 8'd0, 0, 1);

        // top value decrements without wrap issues
        cyc("ff_load", 0, 1, 8'd255, 1, 0, 8'd255, 1, 0);
        cyc("ff_dec",  0, 0, 8'd0, 1, 0, 8'd254, 1, 0);

        // async reset mid-count at 7
        cyc("rs_load", 0, 1, 8'd9, 1, 0, 8'd9, 1, 0);
        cyc("rs_8",    0, 0, 8'd0, 1, 0, 8'd8, 1, 0);
        cyc("rs_7",    0, 0, 8'd0, 1, 0, 8'd7, 1, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_now("rst_mid", 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_1",  0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        cyc("post_2",  0, 0, 8'd0, 1, 0, 8'd0, 0, 0);
        cyc("post_3",  0, 0, 8'd0, 1, 0, 8'd0, 0, 0);

        // auto-reload of 0 pulses every enabled cycle
        cyc("a0_load", 0, 1, 8'd0, 1, 1, 8'd0, 1, 0);
        cyc("a0_d1",   0, 0, 8'd0, 1, 1, 8'd0, 1, 1);
        cyc("a0_d2",   0, 0, 8'd0, 1, 1, 8'd0, 1, 1);
        cyc("a0_off",  0, 0, 8'd0, 0, 1, 8'd0, 1, 0);
        cyc("a0_d3",   0, 0, 8'd0, 1, 1, 8'd0, 1, 1);
        cyc("a0_exp",  0, 0, 8'd0, 1, 0, 8'd0, 0, 1);
        cyc("a0_idle", 0, 0, 8'd0, 1, 1, 8'd0, 0, 0);

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
